crypto_result_arbiter: RTL and testbench
========================================

Name: crypto_result_arbiter

Overview:
Shares the single CV-X-IF result port between several crypto functional units, such as the scalar FU and future multi-cycle AES/SHA units. It merges their results through a round-robin arbiter into a small result FIFO and holds each result until the core asserts result_ready. It also drops results for instructions the core killed through the commit interface. The block sits between the FU outputs and cvxif_resp_o.result* inside the crypto coprocessor.

Parameters:
NumReq, 2, number of requesting functional units (>=2)
Depth, 4, result FIFO entries (power of two, >=2)
XLEN, 64, result data width
IdWidth, 4, CV-X-IF instruction id width
HartIdWidth, 1, hart id width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_valid_i  in  NumReq  FU result valid
req_ready_o  out  NumReq  one-hot grant / accept
req_hartid_i  in  NumReq*HartIdWidth  per-FU hart id
req_id_i  in  NumReq*IdWidth  per-FU instruction id
req_data_i  in  NumReq*XLEN  per-FU result
req_rd_i  in  NumReq*5  per-FU destination register
req_we_i  in  NumReq  per-FU write enable
commit_valid_i  in  1  commit event
commit_id_i  in  IdWidth  committed/killed id
commit_kill_i  in  1  1 = kill commit_id_i
result_valid_o  out  1  result to core
result_ready_i  in  1  core accepts result
result_hartid_o  out  HartIdWidth  result hart id
result_id_o  out  IdWidth  result id
result_data_o  out  XLEN  result data
result_rd_o  out  5  result rd
result_we_o  out  1  result we
occupancy_o  out  $clog2(Depth+1)  FIFO fill level

Behaviour:
- Reset (rst_i=1 at posedge): FIFO pointers, count, kill table and RR pointer are cleared to 0. While rst_i=1: result_valid_o=0, req_ready_o=0, occupancy_o=0. A reset mid-transfer discards all entries; no partial result is emitted.
- Arbitration: combinational, round-robin. Search starts at rr_ptr; first valid requester wins. req_ready_o is one-hot, all-zero if count==Depth, even when a pop occurs the same cycle.
- On an accepted grant g: the entry is written at wptr; wptr wraps modulo Depth; rr_ptr becomes (g+1) mod NumReq. rr_ptr is unchanged if there is no grant.
- Latency: accept at cycle N with FIFO empty -> result_valid_o=1 at N+1. There is no combinational path from req_* to result_*.
- Kill table: kill_q has 2^IdWidth bits.
  - Bit commit_id_i is set on commit_valid_i && commit_kill_i.
  - Exception: the set is ignored when result_valid_o=1 and head.id==commit_id_i. A presented result is never retracted.
- Head handling when count>0:
  - kill_q[head.id]=1: result_valid_o=0; the head is popped that cycle; kill_q[head.id] is cleared. Clear wins over a same-cycle set of the same id.
  - otherwise: result_valid_o=1; the head is popped when result_ready_i=1.
- result_* fields must stay stable while result_valid_o=1 && result_ready_i=0. All result_* data outputs are driven to 0 whenever result_valid_o=0.
- Simultaneous push and pop when 0<count<Depth: count is unchanged and both pointers advance.
- occupancy_o equals the registered count.

Optional Feature:
CRYPTO_RESULT_STATS_EN
- Defined: adds outputs drop_count_o[15:0], counting killed entries popped, and stall_count_o[15:0], counting cycles with result_valid_o && !result_ready_i. Both counters saturate at 0xFFFF and are cleared by rst_i.
- Undefined: these ports and counters do not exist.

Decomposition:
- crypto_instr_pkg gains crypto_result_entry_t, a struct holding hartid, id, data, rd and we, parameterised through the module types.
- Sub-module crypto_rr_arbiter (NumReq): request/enable in, one-hot grant out, owns rr_ptr.

Test Plan:
1. Single request: FU0 sends id=3, data=0xDEADBEEF, rd=5, we=1, with result_ready=1 -> next cycle result_valid=1, id=3, data=0xDEADBEEF; occupancy goes 1 then 0.
2. Both FUs hold valid continuously with ready=1 -> grants alternate 0,1,0,1; 8 results come out in grant order.
3. Backpressure: ready=0, FU0 pushes ids 0..4 -> 4 accepted, req_ready_o=0, occupancy=4, outputs stable on id 0. Then ready=1 -> ids 0,1,2,3 out, then 4 is accepted.
4. Kill before arrival: commit kill id=7, then FU1 delivers id=7 and id=8 -> only id=8 is presented; drop_count_o=1 (stats build); kill_q[7] reads 0 afterwards.
5. Kill of presented head: head id=2 with valid=1 and ready=0, then commit kill id=2 -> valid stays 1; ready=1 pops id=2; a later id=2 result is presented normally.
6. Reset mid-operation: occupancy=3, assert rst_i one cycle -> next cycle result_valid=0, occupancy=0, req_ready_o=0 during reset; a new request is accepted after reset.

Source files
------------

// File: rtl/crypto_instr_pkg.sv
// Shared types and helpers for the crypto coprocessor result path.
// Result entries are declared in the arbiter because their widths follow its parameters.
package crypto_instr_pkg;

    localparam int unsigned RdWidth = 5;
    localparam logic [15:0] StatMax = 16'hFFFF;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_PRESENT,
        HEAD_DROP
    } head_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == StatMax) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crypto_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
// The pointer moves one past the winner only when a grant is issued.
module crypto_rr_arbiter #(
    parameter int unsigned NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int unsigned PtrW = $clog2(NumReq);

    logic [PtrW-1:0] rr_ptr_q;
    logic [PtrW-1:0] rr_ptr_d;
    logic            found;
    int unsigned     idx;

    always_comb begin
        gnt_o    = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (enable_i && !found && req_i[idx[PtrW-1:0]]) begin
                found                = 1'b1;
                gnt_o[idx[PtrW-1:0]] = 1'b1;
                rr_ptr_d             = (idx + 1 >= NumReq) ? '0 : PtrW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/crypto_result_arbiter.sv
// Merges crypto FU results into a result FIFO feeding the CV-X-IF result port, dropping killed ids.
// Optional CRYPTO_RESULT_STATS_EN adds saturating drop/stall counters.
module crypto_result_arbiter
    import crypto_instr_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned Depth       = 4,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned HartIdWidth = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*HartIdWidth-1:0] req_hartid_i,
    input  logic [NumReq*IdWidth-1:0]     req_id_i,
    input  logic [NumReq*XLEN-1:0]        req_data_i,
    input  logic [NumReq*5-1:0]           req_rd_i,
    input  logic [NumReq-1:0]             req_we_i,
    input  logic                          commit_valid_i,
    input  logic [IdWidth-1:0]            commit_id_i,
    input  logic                          commit_kill_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [HartIdWidth-1:0]        result_hartid_o,
    output logic [IdWidth-1:0]            result_id_o,
    output logic [XLEN-1:0]               result_data_o,
    output logic [4:0]                    result_rd_o,
    output logic                          result_we_o,
    output logic [$clog2(Depth+1)-1:0]    occupancy_o
`ifdef CRYPTO_RESULT_STATS_EN
    ,
    output logic [15:0]                   drop_count_o,
    output logic [15:0]                   stall_count_o
`endif
);

    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned KillN = 1 << IdWidth;

    typedef struct packed {
        logic [HartIdWidth-1:0] hartid;
        logic [IdWidth-1:0]     id;
        logic [XLEN-1:0]        data;
        logic [RdWidth-1:0]     rd;
        logic                   we;
    } crypto_result_entry_t;

    crypto_result_entry_t mem_q [Depth];
    crypto_result_entry_t in_entry;
    crypto_result_entry_t head;

    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [CntW-1:0]   count_q;
    logic [KillN-1:0]  kill_q;
    logic [KillN-1:0]  kill_d;
    logic [NumReq-1:0] gnt;
    logic              arb_enable;
    logic              push;
    logic              pop;
    head_state_e       head_state;

    // Full blocks grants even if the head pops this cycle, keeping ready off the result path.
    assign arb_enable = !rst_i && (count_q != CntW'(Depth));

    crypto_rr_arbiter #(
        .NumReq(NumReq)
    ) u_rr_arbiter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable_i(arb_enable),
        .req_i   (req_valid_i),
        .gnt_o   (gnt)
    );

    assign req_ready_o = gnt;
    assign push        = |gnt;

    always_comb begin
        in_entry = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                in_entry.hartid = req_hartid_i[i*HartIdWidth +: HartIdWidth];
                in_entry.id     = req_id_i[i*IdWidth +: IdWidth];
                in_entry.data   = req_data_i[i*XLEN +: XLEN];
                in_entry.rd     = req_rd_i[i*RdWidth +: RdWidth];
                in_entry.we     = req_we_i[i];
            end
        end
    end

    assign head = mem_q[rptr_q];

    always_comb begin
        head_state = HEAD_EMPTY;
        if (!rst_i && count_q != '0) begin
            head_state = kill_q[head.id] ? HEAD_DROP : HEAD_PRESENT;
        end
    end

    assign result_valid_o = (head_state == HEAD_PRESENT);
    assign pop = (head_state == HEAD_DROP) || (result_valid_o && result_ready_i);

    // A kill aimed at the presented head is ignored; clearing on drop beats a same-cycle set.
    always_comb begin
        kill_d = kill_q;
        if (commit_valid_i && commit_kill_i && !(result_valid_o && head.id == commit_id_i)) begin
            kill_d[commit_id_i] = 1'b1;
        end
        if (head_state == HEAD_DROP) begin
            kill_d[head.id] = 1'b0;
        end
    end

    assign result_hartid_o = result_valid_o ? head.hartid : '0;
    assign result_id_o     = result_valid_o ? head.id     : '0;
    assign result_data_o   = result_valid_o ? head.data   : '0;
    assign result_rd_o     = result_valid_o ? head.rd     : '0;
    assign result_we_o     = result_valid_o ? head.we     : 1'b0;
    assign occupancy_o     = rst_i ? '0 : count_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            kill_q  <= '0;
        end else begin
            kill_q <= kill_d;
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CRYPTO_RESULT_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_count_o  <= '0;
            stall_count_o <= '0;
        end else begin
            if (head_state == HEAD_DROP) begin
                drop_count_o <= sat_inc16(drop_count_o);
            end
            if (result_valid_o && !result_ready_i) begin
                stall_count_o <= sat_inc16(stall_count_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_crypto_result_arbiter.sv
// Scoreboard bench for crypto_result_arbiter: directed scenarios then random traffic.
// Build with CRYPTO_RESULT_STATS_EN defined to also check the drop/stall counters.
module tb_crypto_result_arbiter;

    localparam int NumReq      = 2;
    localparam int Depth       = 4;
    localparam int XLEN        = 64;
    localparam int IdWidth     = 4;
    localparam int HartIdWidth = 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_valid_i = '0;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_hartid_i = '0;
    logic [7:0]  req_id_i = '0;
    logic [127:0] req_data_i = '0;
    logic [9:0]  req_rd_i = '0;
    logic [1:0]  req_we_i = '0;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [0:0]  result_hartid_o;
    logic [3:0]  result_id_o;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [2:0]  occupancy_o;
`ifdef CRYPTO_RESULT_STATS_EN
    logic [15:0] drop_count_o;
    logic [15:0] stall_count_o;
`endif

    always #5 clk_i = ~clk_i;

    crypto_result_arbiter #(
        .NumReq(NumReq), .Depth(Depth), .XLEN(XLEN), .IdWidth(IdWidth), .HartIdWidth(HartIdWidth)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_hartid_i(req_hartid_i), .req_id_i(req_id_i), .req_data_i(req_data_i),
        .req_rd_i(req_rd_i), .req_we_i(req_we_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_hartid_o(result_hartid_o), .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .occupancy_o(occupancy_o)
`ifdef CRYPTO_RESULT_STATS_EN
        , .drop_count_o(drop_count_o), .stall_count_o(stall_count_o)
`endif
    );

    typedef struct packed {
        logic [0:0]  hartid;
        logic [3:0]  id;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t  exp_q[$];
    ent_t  pend;
    ent_t  head;
    bit    pend_ok;
    bit    presented;
    bit    dropping;
    bit [15:0] kill_set;
    int    rr;
    int    g;
    int    pidx;
    int    checks = 0;
    int    failures = 0;
    int    drops_exp = 0;
    int    stalls_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance side: predicts the grant from the queue fill and round-robin rule, then enqueues.
    always @(posedge clk_i) begin
        #2;
        pend_ok = 1'b0;
        if (rst_i) begin
            rr = 0;
            chk("rst_ready", 64'(req_ready_o), 64'd0);
        end else begin
            g = -1;
            if (exp_q.size() < Depth) begin
                for (int k = 0; k < NumReq; k++) begin
                    pidx = (rr + k) % NumReq;
                    if (g < 0 && req_valid_i[pidx]) g = pidx;
                end
            end
            chk("grant", 64'(req_ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
                pend.hartid = req_hartid_i[g*HartIdWidth +: HartIdWidth];
                pend.id     = req_id_i[g*IdWidth +: IdWidth];
                pend.data   = req_data_i[g*XLEN +: XLEN];
                pend.rd     = req_rd_i[g*5 +: 5];
                pend.we     = req_we_i[g];
                pend_ok     = 1'b1;
                rr          = (g + 1) % NumReq;
            end
        end
        #2;
        if (pend_ok) exp_q.push_back(pend);
    end

    // Monitor: compares the presented result against the queue head and applies kill rules.
    always @(posedge clk_i) begin
        #3;
        if (rst_i) begin
            chk("rst_valid", 64'(result_valid_o), 64'd0);
            chk("rst_occupancy", 64'(occupancy_o), 64'd0);
            exp_q.delete();
            kill_set   = '0;
            drops_exp  = 0;
            stalls_exp = 0;
        end else begin
`ifdef CRYPTO_RESULT_STATS_EN
            chk("drop_count", 64'(drop_count_o), 64'(drops_exp));
            chk("stall_count", 64'(stall_count_o), 64'(stalls_exp));
`endif
            chk("occupancy", 64'(occupancy_o), 64'(exp_q.size()));
            presented = 1'b0;
            dropping  = 1'b0;
            head      = '0;
            if (exp_q.size() > 0) head = exp_q[0];
            if (exp_q.size() > 0 && kill_set[head.id]) begin
                dropping = 1'b1;
                chk("drop_valid", 64'(result_valid_o), 64'd0);
                chk("drop_zero_data", result_data_o, 64'd0);
            end else if (exp_q.size() > 0) begin
                presented = 1'b1;
                chk("valid", 64'(result_valid_o), 64'd1);
                chk("id", 64'(result_id_o), 64'(head.id));
                chk("data", result_data_o, head.data);
                chk("rd", 64'(result_rd_o), 64'(head.rd));
                chk("we", 64'(result_we_o), 64'(head.we));
                chk("hartid", 64'(result_hartid_o), 64'(head.hartid));
                if (result_ready_i) void'(exp_q.pop_front());
                else stalls_exp++;
            end else begin
                chk("idle_valid", 64'(result_valid_o), 64'd0);
                chk("idle_zero_id", 64'(result_id_o), 64'd0);
            end
            if (commit_valid_i && commit_kill_i && !(presented && head.id == commit_id_i))
                kill_set[commit_id_i] = 1'b1;
            if (dropping) begin
                kill_set[head.id] = 1'b0;
                void'(exp_q.pop_front());
                drops_exp++;
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [3:0] id0, input logic [3:0] id1,
                         input logic rdy, input logic cv, input logic ck, input logic [3:0] cid);
        @(posedge clk_i);
        #1;
        rst_i          = 1'b0;
        req_valid_i    = v;
        req_id_i       = {id1, id0};
        req_data_i     = {$urandom, $urandom, $urandom, $urandom};
        req_rd_i       = 10'($urandom);
        req_we_i       = 2'($urandom);
        req_hartid_i   = 2'($urandom);
        result_ready_i = rdy;
        commit_valid_i = cv;
        commit_kill_i  = ck;
        commit_id_i    = cid;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            rst_i          = 1'b1;
            req_valid_i    = '0;
            result_ready_i = 1'b0;
            commit_valid_i = 1'b0;
            commit_kill_i  = 1'b0;
        end
    endtask

    initial begin
        do_reset(3);

        // single request with known payload
        drive(2'b01, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        req_data_i[63:0] = 64'hDEADBEEF;
        req_rd_i[4:0]    = 5'd5;
        req_we_i[0]      = 1'b1;
        repeat (3) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // both FUs requesting continuously
        for (int i = 0; i < 8; i++) drive(2'b11, 4'(2 * i), 4'(2 * i + 1), 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // backpressure until full, then release
        for (int i = 0; i < 4; i++) drive(2'b01, 4'(i), 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) drive(2'b01, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) drive(2'b01, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (6) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // kill before arrival
        drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd7);
        drive(2'b10, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(2'b10, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (4) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(2'b10, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // kill aimed at the presented head is ignored
        drive(2'b01, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) drive(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2);
        drive(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(2'b01, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // reset with three entries queued
        for (int i = 1; i <= 3; i++) drive(2'b01, 4'(i), 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        do_reset(1);
        drive(2'b01, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // random traffic, light then heavy backpressure
        for (int n = 0; n < 600; n++)
            drive(2'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
        for (int n = 0; n < 300; n++)
            drive(2'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 11) == 0), 1'b1, 4'($urandom));

        for (int n = 0; n < 40 && exp_q.size() > 0; n++)
            drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) drive(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
